// File: rtl/adder_arbiter_if.sv
// Request/response bundle for adder_arbiter: NREQ operand-pair requesters in, one sum out.
interface adder_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 32
);
    localparam int unsigned IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [W-1:0]      rsp_data;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_ready;
    logic [31:0]       ops_count;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, ops_count
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, ops_count
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter feeding one registered adder; define ADDER_ARBITER_SATURATE_EN
// to clamp signed overflow instead of wrapping.
module adder_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 32
) (
    input  logic            clk,
    input  logic            rst,
    adder_arbiter_if.slave  bus
);
    localparam int unsigned IDW = $clog2(NREQ);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [W-1:0]   rsp_data_q;
    logic [IDW-1:0] rsp_id_q;
    logic [31:0]    ops_q;

    logic           found_c;
    logic [IDW-1:0] gidx_c;
    int unsigned    idx_c;
    logic           can_accept_c;
    logic           accept_c;
    logic [NREQ-1:0] ready_c;
    logic [W-1:0]   op_a_c;
    logic [W-1:0]   op_b_c;
    logic [W-1:0]   sum_c;
    logic [W-1:0]   result_c;

    // First valid requester scanning upward from ptr, wrapping at NREQ.
    always_comb begin
        found_c = 1'b0;
        gidx_c  = '0;
        idx_c   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx_c = (32'(ptr) + k) % NREQ;
            if (!found_c && bus.req_valid[IDW'(idx_c)]) begin
                found_c = 1'b1;
                gidx_c  = IDW'(idx_c);
            end
        end
    end

    assign can_accept_c = !rst && ((state == EMPTY) || bus.rsp_ready);
    assign accept_c     = can_accept_c && found_c;

    always_comb begin
        ready_c         = '0;
        ready_c[gidx_c] = accept_c;
    end

    assign op_a_c = bus.req_a[32'(gidx_c)*W +: W];
    assign op_b_c = bus.req_b[32'(gidx_c)*W +: W];
    assign sum_c  = op_a_c + op_b_c;

`ifdef ADDER_ARBITER_SATURATE_EN
    logic ovf_c;
    // Overflow only when both operands share a sign the sum does not.
    assign ovf_c    = (op_a_c[W-1] == op_b_c[W-1]) && (sum_c[W-1] != op_a_c[W-1]);
    assign result_c = !ovf_c      ? sum_c :
                      op_a_c[W-1] ? {1'b1, {(W-1){1'b0}}} :
                                    {1'b0, {(W-1){1'b1}}};
`else
    assign result_c = sum_c;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            ptr        <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
            ops_q      <= '0;
        end else begin
            if ((state == FULL) && bus.rsp_ready) begin
                ops_q <= ops_q + 32'd1;
            end
            if (accept_c) begin
                state      <= FULL;
                rsp_data_q <= result_c;
                rsp_id_q   <= gidx_c;
                ptr        <= (gidx_c == IDW'(NREQ - 1)) ? '0 : gidx_c + IDW'(1);
            end else if ((state == FULL) && bus.rsp_ready) begin
                state <= EMPTY;
            end
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.rsp_valid = (state == FULL);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.ops_count = ops_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed vector bench for adder_arbiter (NREQ=4, W=32); honours ADDER_ARBITER_SATURATE_EN.
module tb_adder_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 32;

`ifdef ADDER_ARBITER_SATURATE_EN
    localparam logic [31:0] OVF_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] OVF_NEG = 32'h8000_0000;
`else
    localparam logic [31:0] OVF_POS = 32'h8000_0000;
    localparam logic [31:0] OVF_NEG = 32'h7FFF_FFFF;
`endif

    logic clk;
    logic rst;

    adder_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    adder_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [31:0] a;
        logic [31:0] b;
        logic        rr;
        logic [3:0]  rdy;
        logic        rv;
        logic        chk_d;
        logic [31:0] d;
        logic [1:0]  id;
        logic [31:0] ops;
    } vec_t;

    localparam int NV = 24;
    vec_t tbl [NV];

    int n_vec;
    int n_err;

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [31:0] a,
                                input logic [31:0] b, input logic rr, input logic [3:0] rdy,
                                input logic rv, input logic cd, input logic [31:0] d,
                                input logic [1:0] id, input logic [31:0] ops);
        vec_t t;
        t.rst = r; t.valid = v; t.a = a; t.b = b; t.rr = rr; t.rdy = rdy;
        t.rv = rv; t.chk_d = cd; t.d = d; t.id = id; t.ops = ops;
        return t;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got 0x%08h, expected 0x%08h", nm, idx, act, exp);
        end
    endtask

    // Requester i sees a + 16*i and b, so the granted index is visible in the sum.
    task automatic drive(input logic r, input logic [3:0] v, input logic [31:0] a,
                         input logic [31:0] b, input logic rr);
        rst           = r;
        bus.req_valid = v;
        bus.rsp_ready = rr;
        for (int i = 0; i < 4; i++) begin
            bus.req_a[i*32 +: 32] = a + 32'(16 * i);
            bus.req_b[i*32 +: 32] = b;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        n_vec = 0;
        n_err = 0;
        drive(1'b1, 4'h0, 32'd0, 32'd0, 1'b0);

        //             rst  valid a             b             rr   rdy   rv   chk  data          id    ops
        tbl[0]  = mk(1'b1, 4'h0, 32'd0,        32'd0,        1'b0, 4'h0, 1'b0, 1'b1, 32'd0,        2'd0, 32'd0);
        tbl[1]  = mk(1'b1, 4'hF, 32'd0,        32'd0,        1'b1, 4'h0, 1'b0, 1'b1, 32'd0,        2'd0, 32'd0);
        tbl[2]  = mk(1'b0, 4'h1, 32'd5,        32'd7,        1'b1, 4'h1, 1'b1, 1'b1, 32'd12,       2'd0, 32'd0);
        tbl[3]  = mk(1'b0, 4'h0, 32'd0,        32'd0,        1'b1, 4'h0, 1'b0, 1'b0, 32'd0,        2'd0, 32'd1);
        tbl[4]  = mk(1'b1, 4'h0, 32'd0,        32'd0,        1'b1, 4'h0, 1'b0, 1'b1, 32'd0,        2'd0, 32'd0);
        tbl[5]  = mk(1'b0, 4'hF, 32'd100,      32'd1,        1'b1, 4'h1, 1'b1, 1'b1, 32'd101,      2'd0, 32'd0);
        tbl[6]  = mk(1'b0, 4'hF, 32'd100,      32'd1,        1'b1, 4'h2, 1'b1, 1'b1, 32'd117,      2'd1, 32'd1);
        tbl[7]  = mk(1'b0, 4'hF, 32'd100,      32'd1,        1'b1, 4'h4, 1'b1, 1'b1, 32'd133,      2'd2, 32'd2);
        tbl[8]  = mk(1'b0, 4'hF, 32'd100,      32'd1,        1'b1, 4'h8, 1'b1, 1'b1, 32'd149,      2'd3, 32'd3);
        tbl[9]  = mk(1'b0, 4'hF, 32'd100,      32'd1,        1'b1, 4'h1, 1'b1, 1'b1, 32'd101,      2'd0, 32'd4);
        tbl[10] = mk(1'b0, 4'h6, 32'd100,      32'd1,        1'b0, 4'h0, 1'b1, 1'b1, 32'd101,      2'd0, 32'd4);
        tbl[11] = mk(1'b0, 4'h6, 32'd100,      32'd1,        1'b0, 4'h0, 1'b1, 1'b1, 32'd101,      2'd0, 32'd4);
        tbl[12] = mk(1'b0, 4'h6, 32'd100,      32'd1,        1'b0, 4'h0, 1'b1, 1'b1, 32'd101,      2'd0, 32'd4);
        tbl[13] = mk(1'b0, 4'h6, 32'd100,      32'd1,        1'b1, 4'h2, 1'b1, 1'b1, 32'd117,      2'd1, 32'd5);
        tbl[14] = mk(1'b1, 4'hA, 32'd100,      32'd1,        1'b1, 4'h0, 1'b0, 1'b1, 32'd0,        2'd0, 32'd0);
        tbl[15] = mk(1'b0, 4'hA, 32'd100,      32'd1,        1'b1, 4'h2, 1'b1, 1'b1, 32'd117,      2'd1, 32'd0);
        tbl[16] = mk(1'b0, 4'hA, 32'd100,      32'd1,        1'b1, 4'h8, 1'b1, 1'b1, 32'd149,      2'd3, 32'd1);
        tbl[17] = mk(1'b0, 4'hA, 32'd100,      32'd1,        1'b1, 4'h2, 1'b1, 1'b1, 32'd117,      2'd1, 32'd2);
        tbl[18] = mk(1'b0, 4'h0, 32'd0,        32'd0,        1'b1, 4'h0, 1'b0, 1'b0, 32'd0,        2'd0, 32'd3);
        tbl[19] = mk(1'b0, 4'h1, 32'h7FFFFFFF, 32'h1,        1'b1, 4'h1, 1'b1, 1'b1, OVF_POS,      2'd0, 32'd3);
        tbl[20] = mk(1'b0, 4'h1, 32'h80000000, 32'hFFFFFFFF, 1'b1, 4'h1, 1'b1, 1'b1, OVF_NEG,      2'd0, 32'd4);
        tbl[21] = mk(1'b0, 4'h0, 32'd0,        32'd0,        1'b0, 4'h0, 1'b1, 1'b1, OVF_NEG,      2'd0, 32'd4);
        tbl[22] = mk(1'b0, 4'h0, 32'd0,        32'd0,        1'b1, 4'h0, 1'b0, 1'b0, 32'd0,        2'd0, 32'd5);
        tbl[23] = mk(1'b0, 4'h1, 32'hFFFFFFFE, 32'd3,        1'b1, 4'h1, 1'b1, 1'b1, 32'd1,        2'd0, 32'd5);

        tick();
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].rst, tbl[i].valid, tbl[i].a, tbl[i].b, tbl[i].rr);
            #4;
            chk("req_ready", i, 32'(bus.req_ready), 32'(tbl[i].rdy));
            tick();
            chk("rsp_valid", i, 32'(bus.rsp_valid), 32'(tbl[i].rv));
            chk("ops_count", i, bus.ops_count, tbl[i].ops);
            if (tbl[i].chk_d) begin
                chk("rsp_data", i, bus.rsp_data, tbl[i].d);
                chk("rsp_id", i, 32'(bus.rsp_id), 32'(tbl[i].id));
            end
        end

        // A requester that drops valid before being granted leaves ptr untouched.
        drive(1'b1, 4'h0, 32'd0, 32'd0, 1'b0);
        tick();
        drive(1'b0, 4'h4, 32'd50, 32'd1, 1'b1);
        cyc = 0;
        do begin
            tick();
            cyc++;
            bus.req_valid = 4'h0;
            bus.rsp_ready = 1'b0;
        end while (!bus.rsp_valid && cyc < 4);
        chk("seq_wait_rsp", 100, 32'(bus.rsp_valid), 32'd1);
        chk("seq_id", 101, 32'(bus.rsp_id), 32'd2);
        chk("seq_data", 102, bus.rsp_data, 32'd83);
        bus.req_valid = 4'h8;
        #4;
        chk("seq_blocked_ready", 103, 32'(bus.req_ready), 32'd0);
        tick();
        bus.req_valid = 4'h0;
        tick();
        chk("seq_hold_data", 104, bus.rsp_data, 32'd83);
        bus.req_valid = 4'hA;
        bus.rsp_ready = 1'b1;
        #4;
        chk("seq_rr_ready", 105, 32'(bus.req_ready), 32'h8);
        tick();
        chk("seq_rr_id", 106, 32'(bus.rsp_id), 32'd3);
        chk("seq_rr_data", 107, bus.rsp_data, 32'd99);
        chk("seq_ops", 108, bus.ops_count, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
